uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, optional parity,
// single-word holding register with ready/valid handshake, overrun and break handling.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 50000000 / 115200,
   parameter int unsigned BITS_N       = 8,
   parameter int unsigned PARITY_TYPE  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_in,
   input  logic              ready_in,
   output logic [BITS_N-1:0] data_rx,
   output logic              valid_out,
   output logic              parity_error,
   output logic              framing_error,
   output logic              overrun,
   output logic              busy
);

   localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W   = $clog2(BITS_N);
   localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
   localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_sync1;
   logic                r_sync2;
   logic [CNT_W-1:0]    r_cnt;
   logic [BIT_W-1:0]    r_bit;
   logic [BITS_N-1:0]   r_shift;
   logic [BITS_N-1:0]   r_data;
   logic                r_par_pend;
   logic                r_valid;
   logic                r_perr;
   logic                r_ferr;
   logic                r_ovr;
   logic                r_busy;

   logic                w_rx;
   logic                w_half;
   logic                w_full;
   logic                w_last_bit;
   logic                w_par_exp;
   logic                w_cnt_clr;
   logic                w_cnt_run;
   logic                w_smp_data;
   logic                w_smp_par;
   logic                w_done;

   assign w_rx       = r_sync2;
   assign w_half     = (r_cnt == CNT_W'(HALF_M1));
   assign w_full     = (r_cnt == CNT_W'(FULL_M1));
   assign w_last_bit = (r_bit == BIT_W'(BITS_N - 1));
   assign w_par_exp  = (PARITY_TYPE == 1) ? ~^r_shift : ^r_shift;

   // Line synchronizer; resets to the idle (high) level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= uart_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (!w_rx) w_state_nxt = S_START;
         S_START:  if (w_half) w_state_nxt = w_rx ? S_IDLE : S_DATA;
         S_DATA:   if (w_full && w_last_bit)
                      w_state_nxt = (PARITY_TYPE != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (w_full) w_state_nxt = S_STOP;
         S_STOP:   if (w_full) w_state_nxt = w_rx ? S_IDLE : S_BREAK;
         S_BREAK:  if (w_rx) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Per-state datapath strobes
   always_comb begin
      w_cnt_clr  = (w_state_nxt != r_state);
      w_cnt_run  = 1'b0;
      w_smp_data = 1'b0;
      w_smp_par  = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         S_START:  w_cnt_run = 1'b1;
         S_DATA:   begin w_cnt_run = 1'b1; w_smp_data = w_full; end
         S_PARITY: begin w_cnt_run = 1'b1; w_smp_par  = w_full; end
         S_STOP:   begin w_cnt_run = 1'b1; w_done     = w_full; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_par_pend <= 1'b0;
      end else begin
         if (w_cnt_clr || w_smp_data) r_cnt <= '0;
         else if (w_cnt_run)          r_cnt <= r_cnt + CNT_W'(1);

         if (r_state != S_DATA) r_bit <= '0;
         else if (w_smp_data)   r_bit <= r_bit + BIT_W'(1);

         if (w_smp_data) r_shift[r_bit] <= w_rx;

         if (r_state == S_IDLE) r_par_pend <= 1'b0;
         else if (w_smp_par)    r_par_pend <= (w_rx != w_par_exp);
      end
   end

   // Holding register: a new frame is dropped only if the held word is not taken this cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         if (w_done && (!r_valid || ready_in)) begin
            r_data  <= r_shift;
            r_perr  <= r_par_pend;
            r_ferr  <= !w_rx;
            r_valid <= 1'b1;
         end else if (r_valid && ready_in) begin
            r_valid <= 1'b0;
         end
         r_ovr  <= w_done && r_valid && !ready_in;
         r_busy <= (w_state_nxt != S_IDLE);
      end
   end

   assign data_rx       = r_data;
   assign valid_out     = r_valid;
   assign parity_error  = r_perr;
   assign framing_error = r_ferr;
   assign overrun       = r_ovr;
   assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (no/odd/even parity) checked every cycle
// against a frame-level model, plus directed literal checks.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int NB  = 8;

   typedef struct {
      int         d;
      int         edge_n;
      logic [7:0] data;
      bit         perr;
      bit         ferr;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       line  [3];
   logic       rdy   [3];
   logic [7:0] dout  [3];
   logic       vld   [3];
   logic       perr  [3];
   logic       ferr  [3];
   logic       ovr   [3];
   logic       bsy   [3];

   int         rdy_mode [3];
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         last_f  = 0;
   ev_t        evq [$];

   bit         m_valid [3];
   bit         m_ovr   [3];
   logic [7:0] m_data  [3];
   bit         m_perr  [3];
   bit         m_ferr  [3];

   bit         vld_q     [3];
   int         rise_cnt  [3];
   int         rise_edge [3];
   logic [7:0] rise_data [3];
   bit         rise_perr [3];
   bit         rise_ferr [3];
   int         ovr_cnt   [3];

   uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(NB), .PARITY_TYPE(0)) u_p0 (
      .clk(clk), .rst(rst), .uart_in(line[0]), .ready_in(rdy[0]), .data_rx(dout[0]),
      .valid_out(vld[0]), .parity_error(perr[0]), .framing_error(ferr[0]),
      .overrun(ovr[0]), .busy(bsy[0]));

   uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(NB), .PARITY_TYPE(1)) u_p1 (
      .clk(clk), .rst(rst), .uart_in(line[1]), .ready_in(rdy[1]), .data_rx(dout[1]),
      .valid_out(vld[1]), .parity_error(perr[1]), .framing_error(ferr[1]),
      .overrun(ovr[1]), .busy(bsy[1]));

   uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(NB), .PARITY_TYPE(2)) u_p2 (
      .clk(clk), .rst(rst), .uart_in(line[2]), .ready_in(rdy[2]), .data_rx(dout[2]),
      .valid_out(vld[2]), .parity_error(perr[2]), .framing_error(ferr[2]),
      .overrun(ovr[2]), .busy(bsy[2]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int d, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp_v, cyc);
      end
   endtask

   // Ready drivers: 0 = hold off, 1 = always accept, 2 = random
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         case (rdy_mode[d])
            0:       rdy[d] <= 1'b0;
            1:       rdy[d] <= 1'b1;
            default: rdy[d] <= ($urandom_range(0, 3) == 0);
         endcase
      end
   end

   // Frame-level model: each sent frame becomes one completion event at a known edge
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 3; d++) begin
            m_valid[d] <= 1'b0;
            m_ovr[d]   <= 1'b0;
            m_data[d]  <= 8'h00;
            m_perr[d]  <= 1'b0;
            m_ferr[d]  <= 1'b0;
         end
         evq.delete();
      end else begin
         for (int d = 0; d < 3; d++) begin
            m_ovr[d] <= 1'b0;
            if (evq.size() > 0 && evq[0].d == d && evq[0].edge_n == cyc) begin
               if (!m_valid[d] || rdy[d]) begin
                  m_valid[d] <= 1'b1;
                  m_data[d]  <= evq[0].data;
                  m_perr[d]  <= evq[0].perr;
                  m_ferr[d]  <= evq[0].ferr;
               end else begin
                  m_ovr[d] <= 1'b1;
               end
               void'(evq.pop_front());
            end else if (m_valid[d] && rdy[d]) begin
               m_valid[d] <= 1'b0;
            end
         end
      end
   end

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      if (rst) begin
         for (int d = 0; d < 3; d++) begin
            check("valid_out", d, int'(vld[d]), int'(m_valid[d]));
            check("overrun", d, int'(ovr[d]), int'(m_ovr[d]));
            if (m_valid[d]) begin
               check("data_rx", d, int'(dout[d]), int'(m_data[d]));
               check("parity_error", d, int'(perr[d]), int'(m_perr[d]));
               check("framing_error", d, int'(ferr[d]), int'(m_ferr[d]));
            end
         end
         check("parity_error_none", 0, int'(perr[0]), 0);
      end
   end

   // Event monitor for directed literal checks
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         vld_q[d] <= vld[d];
         if (vld[d] && !vld_q[d]) begin
            rise_cnt[d]  <= rise_cnt[d] + 1;
            rise_edge[d] <= cyc - 1;
            rise_data[d] <= dout[d];
            rise_perr[d] <= perr[d];
            rise_ferr[d] <= ferr[d];
         end
         if (ovr[d]) ovr_cnt[d] <= ovr_cnt[d] + 1;
      end
   end

   task automatic idle(input int d, input int n);
      line[d] = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives start, data, optional parity and stop; leaves the line at the stop level
   task automatic send_frame(input int d, input logic [7:0] data, input bit pbit, input bit stop);
      int  f;
      int  ones;
      ev_t e;
      line[d] = 1'b0;
      f = cyc;
      ones = $countones(data);
      e.d    = d;
      e.data = data;
      e.ferr = !stop;
      if (d == 0)      e.perr = 1'b0;
      else if (d == 1) e.perr = ((ones + int'(pbit)) % 2) == 0;
      else             e.perr = ((ones + int'(pbit)) % 2) == 1;
      // 2 sync edges + 1 detect edge, half a bit to mid-start, then one bit per remaining bit
      e.edge_n = f + 2 + CPB / 2 + CPB * (NB + (d != 0 ? 1 : 0) + 1);
      evq.push_back(e);
      last_f = f;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < NB; i++) begin
         line[d] = data[i];
         repeat (CPB) @(negedge clk);
      end
      if (d != 0) begin
         line[d] = pbit;
         repeat (CPB) @(negedge clk);
      end
      line[d] = stop;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic check_reset_outputs;
      for (int d = 0; d < 3; d++) begin
         check("rst_data_rx", d, int'(dout[d]), 0);
         check("rst_valid_out", d, int'(vld[d]), 0);
         check("rst_parity_error", d, int'(perr[d]), 0);
         check("rst_framing_error", d, int'(ferr[d]), 0);
         check("rst_overrun", d, int'(ovr[d]), 0);
         check("rst_busy", d, int'(bsy[d]), 0);
      end
   endtask

   initial begin
      int c;
      int o;
      for (int d = 0; d < 3; d++) begin
         line[d]     = 1'b1;
         rdy_mode[d] = 1;
      end
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // Plain frame, always ready
      c = rise_cnt[0];
      send_frame(0, 8'hA5, 1'b0, 1'b1);
      idle(0, 8);
      check("a5_pulses", 0, rise_cnt[0] - c, 1);
      check("a5_data", 0, int'(rise_data[0]), 8'hA5);
      check("a5_perr", 0, int'(rise_perr[0]), 0);
      check("a5_ferr", 0, int'(rise_ferr[0]), 0);
      check("a5_latency", 0, rise_edge[0] - last_f, 154);
      check("a5_valid_low", 0, int'(vld[0]), 0);

      // Even and odd parity on 0x3C
      send_frame(2, 8'h3C, 1'b0, 1'b1);
      idle(2, 8);
      check("even_ok_perr", 2, int'(rise_perr[2]), 0);
      check("even_latency", 2, rise_edge[2] - last_f, 170);
      send_frame(2, 8'h3C, 1'b1, 1'b1);
      idle(2, 8);
      check("even_bad_data", 2, int'(rise_data[2]), 8'h3C);
      check("even_bad_perr", 2, int'(rise_perr[2]), 1);
      send_frame(1, 8'h3C, 1'b1, 1'b1);
      idle(1, 8);
      check("odd_ok_perr", 1, int'(rise_perr[1]), 0);
      send_frame(1, 8'h3C, 1'b0, 1'b1);
      idle(1, 8);
      check("odd_bad_perr", 1, int'(rise_perr[1]), 1);

      // Five-cycle low glitch
      c = rise_cnt[0];
      line[0] = 1'b0;
      repeat (5) @(negedge clk);
      line[0] = 1'b1;
      repeat (3) @(negedge clk);
      check("glitch_busy", 0, int'(bsy[0]), 1);
      repeat (20) @(negedge clk);
      check("glitch_idle", 0, int'(bsy[0]), 0);
      check("glitch_no_frame", 0, rise_cnt[0] - c, 0);

      // Bad stop bit then a 40-bit break
      c = rise_cnt[0];
      send_frame(0, 8'h55, 1'b0, 1'b0);
      repeat (20 * CPB) @(negedge clk);
      check("break_busy", 0, int'(bsy[0]), 1);
      repeat (20 * CPB) @(negedge clk);
      check("break_one_frame", 0, rise_cnt[0] - c, 1);
      check("break_data", 0, int'(rise_data[0]), 8'h55);
      check("break_ferr", 0, int'(rise_ferr[0]), 1);
      idle(0, 5);
      check("break_exit", 0, int'(bsy[0]), 0);
      send_frame(0, 8'hC3, 1'b0, 1'b1);
      idle(0, 8);
      check("after_break_data", 0, int'(rise_data[0]), 8'hC3);

      // Overrun with consumer stalled
      rdy_mode[0] = 0;
      idle(0, 4);
      o = ovr_cnt[0];
      send_frame(0, 8'h11, 1'b0, 1'b1);
      idle(0, 2);
      send_frame(0, 8'h22, 1'b0, 1'b1);
      idle(0, 10);
      check("ovr_pulses", 0, ovr_cnt[0] - o, 1);
      check("ovr_held_data", 0, int'(dout[0]), 8'h11);
      check("ovr_held_valid", 0, int'(vld[0]), 1);
      rdy_mode[0] = 1;
      idle(0, 4);
      check("ovr_accept_clears", 0, int'(vld[0]), 0);

      // Reset in the middle of data bit 3
      line[0] = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         line[0] = 1'b1;
         repeat (CPB) @(negedge clk);
      end
      line[0] = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      idle(0, 3);
      rst = 1'b1;
      idle(0, 5);
      send_frame(0, 8'h81, 1'b0, 1'b1);
      idle(0, 8);
      check("post_rst_data", 0, int'(rise_data[0]), 8'h81);
      check("post_rst_ferr", 0, int'(rise_ferr[0]), 0);

      // Randomized traffic across all three instances
      for (int it = 0; it < 60; it++) begin
         int  d;
         bit  stop;
         d = $urandom_range(0, 2);
         rdy_mode[d] = $urandom_range(0, 2);
         stop = ($urandom_range(0, 9) != 0);
         send_frame(d, 8'($urandom), 1'($urandom), stop);
         if (!stop) repeat ($urandom_range(0, 3 * CPB)) @(negedge clk);
         idle(d, stop ? $urandom_range(0, 30) : $urandom_range(2, 30));
      end
      for (int d = 0; d < 3; d++) rdy_mode[d] = 1;
      repeat (40) @(negedge clk);
      for (int d = 0; d < 3; d++) check("drained_valid", d, int'(vld[d]), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
